// File: rtl/uart_wb_peripheral_pkg.sv
// uart_wb_pkg: register addresses, CTRL/STATUS bit positions, TX FSM states and address decode helper
package uart_wb_pkg;
  localparam logic [2:0] ADR_CTRL = 3'h3;
  localparam logic [2:0] ADR_BAUD = 3'h4;
  localparam logic [2:0] ADR_STATUS = 3'h5;
  localparam logic [2:0] ADR_TXBUF = 3'h7;
  localparam int CTRL_START = 7;
  localparam int STAT_DONE = 5;
  localparam int STAT_BUSY = 0;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;
  function automatic logic reg_mapped(input logic [31:0] adr);
    return adr[31:3] == '0 && adr[2:0] inside {ADR_CTRL, ADR_BAUD, ADR_STATUS, ADR_TXBUF};
  endfunction
endpackage

// File: rtl/uart_wb_peripheral_if.sv
// uart_wb_if: Wishbone slave bus (adr_i, dat_i, we_i, sel_i, cyc_i, stb_i in; dat_o, ack_o, err_o out)
interface uart_wb_if;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0] sel_i;
  logic we_i;
  logic cyc_i;
  logic stb_i;
  logic ack_o;
  logic err_o;
  modport master(output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, input dat_o, ack_o, err_o);
  modport slave(input adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, output dat_o, ack_o, err_o);
endinterface

// File: rtl/uart_wb_peripheral_baud_nco.sv
// uart_baud_nco: 32-bit phase accumulator (clk_i, rst_i, en, clr, inc in; tick = carry-out while en)
module uart_baud_nco (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] inc,
  output logic        tick
);
  logic [31:0] acc;
  logic [32:0] sum;
  assign sum = {1'b0, acc} + {1'b0, inc};
  assign tick = en & sum[32];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) acc <= '0;
    else acc <= clr ? '0 : en ? sum[31:0] : acc;
endmodule

// File: rtl/uart_wb_peripheral.sv
// uart_wb_peripheral: Wishbone-mapped UART transmitter (clk_i, rst_i, bus slave; tx_o serial out, busy_o frame active)
module uart_wb_peripheral
  import uart_wb_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic      clk_i,
  input  logic      rst_i,
  uart_wb_if.slave  bus,
  output logic      tx_o,
  output logic      busy_o
);
  logic [1:0] state;
  logic [7:0] txbuf, shreg;
  logic [31:0] baud, status, rdata;
  logic [2:0] cnt;
  logic done, tick, req, map, wr, start, done_set, unused_ok;
  assign unused_ok = ^{bus.sel_i, 32'(CLK_HZ)};
  assign req = bus.cyc_i & bus.stb_i & ~bus.ack_o & ~bus.err_o;
  assign map = reg_mapped(bus.adr_i);
  assign wr = req & map & bus.we_i;
  assign start = wr & bus.adr_i[2:0] == ADR_CTRL & bus.dat_i[CTRL_START] & state == ST_IDLE;
  assign done_set = tick & state == ST_STOP;
  assign busy_o = state != ST_IDLE;
  assign tx_o = state == ST_START ? 1'b0 : state == ST_DATA ? shreg[0] : 1'b1;
  assign status = (32'(done) << STAT_DONE) | (32'(busy_o) << STAT_BUSY);
  always_comb
    rdata = bus.adr_i[2:0] == ADR_BAUD ? baud :
            bus.adr_i[2:0] == ADR_STATUS ? status :
            bus.adr_i[2:0] == ADR_TXBUF ? {24'b0, txbuf} : '0;
  uart_baud_nco u_nco (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en(busy_o),
    .clr(~busy_o),
    .inc(baud),
    .tick(tick)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      bus.ack_o <= 1'b0;
      bus.err_o <= 1'b0;
      bus.dat_o <= '0;
    end else begin
      bus.ack_o <= req & map;
      bus.err_o <= req & ~map;
      bus.dat_o <= req & map & ~bus.we_i ? rdata : '0;
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      baud <= '0;
      txbuf <= '0;
      done <= 1'b0;
    end else begin
      if (wr && bus.adr_i[2:0] == ADR_BAUD) baud <= bus.dat_i;
      if (wr && bus.adr_i[2:0] == ADR_TXBUF) txbuf <= bus.dat_i[7:0];
      done <= done_set | (done & ~(wr & bus.adr_i[2:0] == ADR_STATUS & ~bus.dat_i[STAT_DONE]));
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt <= '0;
    end else if (start) begin
      state <= ST_START;
      shreg <= txbuf;
      cnt <= '0;
    end else if (tick) begin
      case (state)
        ST_START: state <= ST_DATA;
        ST_DATA: begin
          shreg <= shreg >> 1;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= ST_STOP;
        end
        ST_STOP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_wb_peripheral.sv
// tb_uart_wb_peripheral: directed bench with a tick-counting frame model checked every cycle
module tb_uart_wb_peripheral;
  logic clk = 0;
  logic rst = 1;
  logic tx, busy;
  int total = 0;
  int bad = 0;
  uart_wb_if bus();
  uart_wb_peripheral dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus.slave),
    .tx_o(tx),
    .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  logic m_ack = 0, m_err = 0, m_done = 0, m_busy = 0;
  logic [31:0] m_dat = 0, m_baud = 0;
  logic [7:0] m_txbuf = 0, m_frame = 0;
  logic [63:0] m_phase = 0;
  function automatic logic is_mapped(input logic [31:0] a);
    return a == 3 || a == 4 || a == 5 || a == 7;
  endfunction
  function automatic logic exp_tx();
    int t;
    if (!m_busy) return 1'b1;
    t = int'(m_phase[63:32]);
    if (t == 0) return 1'b0;
    if (t <= 8) return m_frame[t-1];
    return 1'b1;
  endfunction
  always @(posedge clk or posedge rst) begin
    logic req, map, ob, od, fin;
    logic [31:0] rd;
    if (rst) begin
      m_ack = 0; m_err = 0; m_done = 0; m_busy = 0;
      m_dat = 0; m_baud = 0; m_txbuf = 0; m_frame = 0; m_phase = 0;
    end else begin
      ob = m_busy;
      od = m_done;
      req = bus.cyc_i && bus.stb_i && !m_ack && !m_err;
      map = is_mapped(bus.adr_i);
      case (bus.adr_i)
        4: rd = m_baud;
        5: rd = od * 32'd32 + ob;
        7: rd = {24'b0, m_txbuf};
        default: rd = 0;
      endcase
      fin = 0;
      if (ob) begin
        m_phase = m_phase + m_baud;
        if (m_phase[63:32] >= 10) begin
          m_busy = 0;
          fin = 1;
        end
      end
      if (req && map && bus.we_i)
        case (bus.adr_i[2:0])
          3: if (bus.dat_i[7] && !ob) begin m_busy = 1; m_phase = 0; m_frame = m_txbuf; end
          4: m_baud = bus.dat_i;
          5: if (!bus.dat_i[5]) m_done = 0;
          7: m_txbuf = bus.dat_i[7:0];
          default: ;
        endcase
      if (fin) m_done = 1;
      m_dat = (req && map && !bus.we_i) ? rd : 0;
      m_ack = req && map;
      m_err = req && !map;
    end
  end
  always @(negedge clk)
    if (!rst) begin
      check("model_ack", 32'(bus.ack_o), 32'(m_ack));
      check("model_err", 32'(bus.err_o), 32'(m_err));
      check("model_dat", bus.dat_o, m_dat);
      check("model_tx", 32'(tx), 32'(exp_tx()));
      check("model_busy", 32'(busy), 32'(m_busy));
    end
  task automatic wb(input logic we, input logic [31:0] a, input logic [31:0] d,
                    output logic ack, output logic err, output logic [31:0] q);
    @(negedge clk);
    bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = we; bus.adr_i = a; bus.dat_i = d; bus.sel_i = 4'hf;
    ack = 0; err = 0; q = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.ack_o || bus.err_o) begin
        ack = bus.ack_o; err = bus.err_o; q = bus.dat_o;
        break;
      end
    end
    bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
    if (!(ack || err)) check("bus_timeout", 0, 1);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic ack, err;
    logic [31:0] q;
    wb(1, a, d, ack, err, q);
    check("wr_ack", 32'(ack), 1);
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic ack, err;
    logic [31:0] q;
    wb(0, a, 0, ack, err, q);
    check(name, q, exp);
  endtask
  task automatic wait_idle(input string name, input int limit);
    for (int i = 0; i < limit && busy; i++) @(negedge clk);
    check(name, 32'(busy), 0);
  endtask
  initial begin
    logic [9:0] pattern;
    logic ack, err, ok;
    logic [31:0] q;
    bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.adr_i = 0; bus.dat_i = 0; bus.sel_i = 0;
    #12;
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(bus.ack_o), 0);
    check("rst_err", 32'(bus.err_o), 0);
    check("rst_dat", bus.dat_o, 0);
    @(negedge clk);
    rst = 0;
    rd(5, 0, "status_rst");
    rd(4, 0, "baud_rst");
    rd(7, 0, "txbuf_rst");
    wr(4, 32'h4000_0000);
    wr(7, 32'h41);
    rd(3, 0, "ctrl_reads0");
    rd(4, 32'h4000_0000, "baud_rw");
    wr(3, 32'h80);
    pattern = 10'b1_0100_0001_0;
    for (int k = 0; k < 40; k++) begin
      check("frame_bit", 32'(tx), 32'(pattern[k/4]));
      @(negedge clk);
    end
    check("frame_end_busy", 32'(busy), 0);
    check("frame_end_tx", 32'(tx), 1);
    rd(5, 32'h20, "status_done");
    wr(5, 0);
    rd(5, 0, "status_clr");
    wr(3, 32'h80);
    rd(5, 32'h01, "status_busy");
    wr(7, 32'h55);
    wr(3, 32'h80);
    rd(7, 32'h55, "txbuf_mid");
    wait_idle("frame2_end", 60);
    ok = 1;
    repeat (12) begin
      @(negedge clk);
      ok &= !busy && tx;
    end
    check("no_second_frame", 32'(ok), 1);
    rd(5, 32'h20, "status_done2");
    wr(5, 0);
    wr(3, 32'h80);
    repeat (38) @(negedge clk);
    wr(5, 0);
    rd(5, 32'h20, "done_set_wins");
    wb(0, 32'h2, 0, ack, err, q);
    check("err_rd_err", 32'(err), 1);
    check("err_rd_ack", 32'(ack), 0);
    check("err_rd_dat", q, 0);
    wb(1, 32'h6, 32'hffff_ffff, ack, err, q);
    check("err_wr_err", 32'(err), 1);
    wb(1, 32'hc, 32'h1234_5678, ack, err, q);
    check("err_hi_adr", 32'(err), 1);
    rd(4, 32'h4000_0000, "baud_kept");
    rd(7, 32'h55, "txbuf_kept");
    wr(7, 32'ha5);
    wr(3, 32'h80);
    repeat (17) @(negedge clk);
    check("pre_rst_bit3", 32'(tx), 0);
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1;
    #1;
    check("mid_rst_tx", 32'(tx), 1);
    check("mid_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 0;
    rd(5, 0, "status_after_rst");
    rd(4, 0, "baud_after_rst");
    wr(7, 32'h3c);
    wr(3, 32'h80);
    ok = 1;
    repeat (1000) begin
      @(negedge clk);
      ok &= !tx && busy;
    end
    check("baud0_hold", 32'(ok), 1);
    wr(4, 32'h4000_0000);
    wait_idle("baud0_resume_end", 100);
    rd(5, 32'h20, "baud0_done");
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_wb_peripheral.md
UART_WB_PERIPHERAL -- requirements
Module: uart_wb_peripheral

Interface
REQ-001 Parameter CLK_HZ, default 50000000, board clock frequency; informational only, no logic depends on it.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset; asynchronous and active-high.
REQ-004 adr_i  input  32  Wishbone address; only adr_i[2:0] decoded, adr_i[31:3] SHALL be zero for a mapped access.
REQ-005 dat_i  input  32  Wishbone write data.
REQ-006 dat_o  output  32  Wishbone read data.
REQ-007 we_i  input  1  write enable.
REQ-008 sel_i  input  4  byte selects; ignored, full-word access always.
REQ-009 cyc_i / stb_i  input  1 each  bus cycle and strobe.
REQ-010 ack_o / err_o  output  1 each  access acknowledge and unmapped-address error.
REQ-011 tx_o  output  1  UART serial out, idle high.
REQ-012 busy_o  output  1  transmission in progress.

Function
REQ-013 Register map: 0x3 CTRL (bit7 START, write-only, self-clearing, reads 0); 0x4 BAUD (32-bit NCO increment, R/W); 0x5 STATUS (bit5 DONE sticky, bit0 BUSY, other bits read 0); 0x7 TXBUF (bits 7:0 R/W, upper bits read 0).
REQ-014 Access qualified when cyc_i & stb_i & ~ack_o & ~err_o; ack_o or err_o pulses high exactly one cycle later for one cycle; back-to-back held strobes therefore complete every second cycle.
REQ-015 Unmapped address: err_o pulses instead of ack_o, no register changes, dat_o = 0.
REQ-016 Reads: dat_o registered, valid in the ack_o cycle; dat_o = 0 outside acked reads.
REQ-017 Writes take effect on the edge where ack_o is raised.
REQ-018 STATUS write with dat_i[5]=0 clears DONE; dat_i[5]=1 leaves it unchanged; BUSY not writable.
REQ-019 Baud tick: 32-bit accumulator adds BAUD each cycle while busy; tick = carry-out of the add; accumulator cleared on start and when idle.
REQ-020 TX FSM states IDLE, START, DATA, STOP.
REQ-021 IDLE -> START on CTRL write with dat_i[7]=1: TXBUF latched into shift register, tx_o=0 next cycle, busy_o=1.
REQ-022 START -> DATA on tick; DATA shifts LSB first, one bit per tick, 3-bit counter, after bit 7's tick -> STOP (tx_o=1).
REQ-023 STOP -> IDLE on tick; in that same edge DONE set, busy_o cleared.
REQ-024 START write while busy_o=1 ignored; TXBUF writes while busy update TXBUF only, frame in flight unaffected.
REQ-025 DONE set and software clear in the same cycle: set wins.
REQ-026 BAUD = 0: no ticks, FSM holds current state indefinitely; BAUD write mid-frame takes effect on the next add.
REQ-027 Frame length exactly 10 ticks from START entry to IDLE return.

Reset
REQ-028 While rst_i=1: FSM IDLE, tx_o=1, busy_o=0, ack_o=0, err_o=0, dat_o=0, BAUD=0, TXBUF=0, DONE=0, accumulator=0, bit counter=0.
REQ-029 Reset mid-frame aborts immediately; tx_o returns high without completing the stop bit, DONE not set.

Structure
REQ-030 Shared package uart_wb_pkg SHALL hold register address constants, CTRL/STATUS bit positions and the TX FSM state enumeration.
REQ-031 One sub-module uart_baud_nco (accumulator plus tick carry, enable and clear inputs); everything else flat.

Verification
REQ-032 Write BAUD=0x40000000, TXBUF=0x41, CTRL=0x80 -> tx_o low 4 cycles, then 1,0,0,0,0,0,1,0 at 4 cycles per bit, stop high, DONE=1 at cycle 40 after start.
REQ-033 Poll STATUS during the frame -> reads 0x01; after frame -> 0x20; write STATUS=0 -> reads 0x00.
REQ-034 Second CTRL=0x80 and TXBUF=0x55 mid-frame -> serial data still 0x41, no second frame.
REQ-035 Read address 0x2 and write 0x6 -> err_o one cycle, no ack_o, registers unchanged.
REQ-036 Assert rst_i during bit 3 -> tx_o=1 and busy_o=0 immediately, STATUS reads 0 after release.
REQ-037 BAUD=0 then CTRL=0x80 -> tx_o held low, busy_o=1 for 1000 cycles; write BAUD=0x40000000 -> frame completes normally.
